// File: rtl/i2c_tx_fifo.sv
// i2c_tx_fifo: transmit byte FIFO between the host and the I2C master.
// The host pushes bytes with write/data_in. The controller pops one byte per
// transfer with read and sees empty as its empty_tx.
// Ports:
//   clk, reset     - system clock; synchronous active-high reset
//   flush          - clears the contents and keeps the error flags
//   write, data_in - host push strobe and byte; full reports no free entry
//   read, data_out - controller pop strobe and registered popped byte
//   empty, level   - occupancy: level counts 0..2^ADDR_WIDTH entries
//   overflow       - sticky flag for a rejected write; cleared by clear_err
//   underflow      - sticky flag for a rejected read; cleared by clear_err
module i2c_tx_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  flush,
    input  logic                  write,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic                  full,
    input  logic                  read,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  empty,
    output logic [ADDR_WIDTH:0]   level,
    output logic                  overflow,
    output logic                  underflow,
    input  logic                  clear_err
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] LEVEL_FULL = {1'b1, {ADDR_WIDTH{1'b0}}};

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [ADDR_WIDTH-1:0] wr_ptr, rd_ptr;
    logic                  rd_ok, wr_ok;

    // full and empty depend only on the level register. This keeps any
    // combinational path from the strobes away from the status outputs.
    assign full  = (level == LEVEL_FULL);
    assign empty = (level == '0);

    // A write on a full FIFO is still accepted if a read frees a slot in the
    // same cycle. A read on an empty FIFO is never accepted, even when a
    // write arrives in the same cycle.
    assign rd_ok = read && !empty;
    assign wr_ok = write && (!full || rd_ok);

    // The storage array has no reset. Stale entries cannot be reached
    // because the pointers are reset.
    always_ff @(posedge clk) begin
        if (!reset && !flush && wr_ok)
            mem[wr_ptr] <= data_in;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            level     <= '0;
            data_out  <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else if (flush) begin
            // data_out and both flags hold their values during a flush.
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (wr_ok)
                wr_ptr <= wr_ptr + 1'b1;
            if (rd_ok) begin
                rd_ptr   <= rd_ptr + 1'b1;
                data_out <= mem[rd_ptr];
            end
            case ({wr_ok, rd_ok})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
            // An error event in the same cycle wins over clear_err.
            if (write && !wr_ok)
                overflow <= 1'b1;
            else if (clear_err)
                overflow <= 1'b0;
            if (read && !rd_ok)
                underflow <= 1'b1;
            else if (clear_err)
                underflow <= 1'b0;
        end
    end

endmodule

// File: tb/tb_i2c_tx_fifo.sv
// Table-driven bench for i2c_tx_fifo. Each record holds the inputs for one
// clock edge and the outputs expected just after that edge.
module tb_i2c_tx_fifo;

    logic       clk = 1'b0;
    logic       reset, flush, write, read, clear_err;
    logic [7:0] data_in, data_out;
    logic       full, empty, overflow, underflow;
    logic [4:0] level;

    typedef struct {
        logic       rst, fl, wr, rd, clr;
        logic [7:0] din;
        logic [4:0] lvl;
        logic [7:0] dout;
        logic       ovf, unf;
    } vec_t;

    vec_t vecs[$];
    int   applied = 0;
    int   miscompares = 0;

    i2c_tx_fifo dut (
        .clk(clk), .reset(reset), .flush(flush), .write(write),
        .data_in(data_in), .full(full), .read(read), .data_out(data_out),
        .empty(empty), .level(level), .overflow(overflow),
        .underflow(underflow), .clear_err(clear_err)
    );

    always #10 clk = ~clk;

    task automatic add(input logic rst, fl, wr, rd, input logic [7:0] din,
                       input logic clr, input logic [4:0] lvl,
                       input logic [7:0] dout, input logic ovf, unf);
        vec_t v;
        v.rst = rst; v.fl = fl; v.wr = wr; v.rd = rd; v.din = din;
        v.clr = clr; v.lvl = lvl; v.dout = dout; v.ovf = ovf; v.unf = unf;
        vecs.push_back(v);
    endtask

    // Drive a record, let one edge pass, then sample 1 time unit after it.
    task automatic apply(input vec_t v, input int idx);
        logic exp_e, exp_f;
        reset = v.rst; flush = v.fl; write = v.wr; read = v.rd;
        data_in = v.din; clear_err = v.clr;
        @(posedge clk);
        #1;
        exp_e = (v.lvl == 5'd0);
        exp_f = (v.lvl == 5'd16);
        applied++;
        if (level !== v.lvl || empty !== exp_e || full !== exp_f ||
            data_out !== v.dout || overflow !== v.ovf || underflow !== v.unf) begin
            miscompares++;
            $display("FAIL vec%0d: got lvl=%0d e=%b f=%b dout=%h ovf=%b unf=%b, want lvl=%0d e=%b f=%b dout=%h ovf=%b unf=%b",
                     idx, level, empty, full, data_out, overflow, underflow,
                     v.lvl, exp_e, exp_f, v.dout, v.ovf, v.unf);
        end
    endtask

    initial begin
        vec_t h;
        reset = 1'b0; flush = 1'b0; write = 1'b0; read = 1'b0;
        data_in = 8'h00; clear_err = 1'b0;

        // Reset for two cycles with write held high.
        add(1,0,1,0,8'hFF,0, 0, 8'h00, 0,0);
        add(1,0,1,0,8'hFF,0, 0, 8'h00, 0,0);
        // Fill 0x00..0x0F, then drain.
        for (int i = 0; i < 16; i++) add(0,0,1,0,8'(i),0, 5'(i+1), 8'h00, 0,0);
        for (int i = 0; i < 16; i++) add(0,0,0,1,8'h00,0, 5'(15-i), 8'(i), 0,0);
        // Wrap-around: write 10, read 10, then write and read 0xA0..0xAB.
        for (int i = 0; i < 10; i++) add(0,0,1,0,8'(8'h10+i),0, 5'(i+1), 8'h0F, 0,0);
        for (int i = 0; i < 10; i++) add(0,0,0,1,8'h00,0, 5'(9-i), 8'(8'h10+i), 0,0);
        for (int i = 0; i < 12; i++) add(0,0,1,0,8'(8'hA0+i),0, 5'(i+1), 8'h19, 0,0);
        for (int i = 0; i < 12; i++) add(0,0,0,1,8'h00,0, 5'(11-i), 8'(8'hA0+i), 0,0);
        // Full with simultaneous events.
        for (int i = 0; i < 16; i++) add(0,0,1,0,8'(8'hC0+i),0, 5'(i+1), 8'hAB, 0,0);
        add(0,0,1,0,8'h55,0, 16, 8'hAB, 1,0);   // rejected write
        add(0,0,1,1,8'h66,0, 16, 8'hC0, 1,0);   // write+read on full
        for (int i = 1; i < 16; i++) add(0,0,0,1,8'h00,0, 5'(16-i), 8'(8'hC0+i), 1,0);
        add(0,0,0,1,8'h00,0, 0, 8'h66, 1,0);    // 0x66 comes out last
        // Empty with simultaneous events.
        add(0,0,0,1,8'h00,0, 0, 8'h66, 1,1);    // rejected read
        add(0,0,1,1,8'h77,0, 1, 8'h66, 1,1);    // write accepted, read not
        add(0,0,0,0,8'h00,1, 1, 8'h66, 0,0);    // clear_err
        add(0,0,0,1,8'h00,0, 0, 8'h77, 0,0);
        add(0,0,0,1,8'h00,1, 0, 8'h77, 0,1);    // error wins over clear_err
        // Flush mid-operation with a flag set.
        for (int i = 0; i < 5; i++) add(0,0,1,0,8'(8'h30+i),0, 5'(i+1), 8'h77, 0,1);
        add(0,1,1,1,8'hEE,0, 0, 8'h77, 0,1);
        add(0,0,1,0,8'h3C,0, 1, 8'h77, 0,1);
        add(0,0,0,1,8'h00,0, 0, 8'h3C, 0,1);
        // A flush on an empty FIFO ignores the strobes and raises no flags.
        add(0,0,0,0,8'h00,1, 0, 8'h3C, 0,0);
        add(0,1,1,1,8'hEE,0, 0, 8'h3C, 0,0);
        // Sustained one write and one read per cycle.
        add(0,0,1,0,8'h81,0, 1, 8'h3C, 0,0);
        for (int i = 0; i < 6; i++) add(0,0,1,1,8'(8'h82+i),0, 1, 8'(8'h81+i), 0,0);
        add(0,0,0,1,8'h00,0, 0, 8'h87, 0,0);

        for (int i = 0; i < vecs.size(); i++) apply(vecs[i], i);

        // Reset in the middle of a burst, with an error flag set.
        h = '{rst:0, fl:0, wr:0, rd:1, clr:0, din:8'h00, lvl:0, dout:8'h87, ovf:0, unf:1};
        apply(h, 1000);
        for (int i = 0; i < 3; i++) begin
            h = '{rst:0, fl:0, wr:1, rd:0, clr:0, din:8'(8'hD0+i), lvl:5'(i+1), dout:8'h87, ovf:0, unf:1};
            apply(h, 1001+i);
        end
        h = '{rst:1, fl:0, wr:1, rd:1, clr:0, din:8'hEE, lvl:0, dout:8'h00, ovf:0, unf:0};
        apply(h, 1004);
        h = '{rst:0, fl:0, wr:1, rd:0, clr:0, din:8'h5A, lvl:1, dout:8'h00, ovf:0, unf:0};
        apply(h, 1005);
        h = '{rst:0, fl:0, wr:0, rd:1, clr:0, din:8'h00, lvl:0, dout:8'h5A, ovf:0, unf:0};
        apply(h, 1006);

        $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
        $finish;
    end

endmodule
